video_mode_sequencer: RTL and testbench



---
 rtl/video_mode_sequencer_pkg.sv | 32 +++
 rtl/video_mode_watchdog.sv | 29 ++
 rtl/video_mode_sequencer.sv | 135 +++++++++++++
 tb/tb_video_mode_sequencer.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_mode_sequencer_pkg.sv
// Shared types for the video mode sequencer: timing record, FSM states, limits.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package video_mode_sequencer_pkg;

  // One screen-mode preset as consumed by the video timing generator.
  typedef struct packed {
    logic [3:0]  clkdiv;
    logic [11:0] hbstart;
    logic [11:0] hsstart;
    logic [11:0] hsstop;
    logic [11:0] htotal;
    logic [11:0] vbstart;
    logic [11:0] vsstart;
    logic [11:0] vsstop;
    logic [11:0] vtotal;
    logic        hpolarity;
    logic        vpolarity;
  } screenmode_timings;

  typedef enum logic [2:0] {
    VMS_IDLE,
    VMS_WAIT_FRAME,
    VMS_HOLD,
    VMS_SETTLE,
    VMS_DONE
  } video_mode_seq_state_t;

  // The generator's reset_n passes a 2-flop synchroniser; shorter holds may be missed.
  localparam int VMS_MIN_HOLD = 4;

endpackage

// File: rtl/video_mode_watchdog.sv
// Saturating timeout counter; expired when every bit is set.
// Latency: expired rises 2^timeoutBits-1 enabled cycles after the last clear.
// Backpressure: none; clear has priority over enable.
// Ports: clk, reset (async, active-high), clear, enable in; expired out.
module video_mode_watchdog #(
  parameter int timeoutBits = 22
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [timeoutBits-1:0] count;

  assign expired = &count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/video_mode_sequencer.sv
// Sequences screen-mode swaps: wait for a frame boundary, hold the timing generator in reset while
// swapping its timings, release it and report completion on the first new frame.
// Latency: request->WAIT_FRAME 1 cycle; frame_stb->HOLD 1 cycle; HOLD lasts holdCycles cycles.
// Backpressure: req_ready is high only in IDLE; req_valid must be held until accepted.
// Ports: clk, reset | modes (preset table) | req_valid/req_mode/req_ready (host request)
//        frame_stb (from generator) | vt_reset_n, timings (to generator)
//        cur_mode, busy, done_stb, err_stb (status).
module video_mode_sequencer
  import video_mode_sequencer_pkg::*;
#(
  parameter int numModes    = 4,
  parameter int modeBits    = 2,
  parameter int defaultMode = 0,
  parameter int holdCycles  = 8,
  parameter int timeoutBits = 22
) (
  input  logic                  clk,
  input  logic                  reset,
  input  screenmode_timings     modes [numModes],
  input  logic                  req_valid,
  input  logic [modeBits-1:0]   req_mode,
  output logic                  req_ready,
  input  logic                  frame_stb,
  output logic                  vt_reset_n,
  output screenmode_timings     timings,
  output logic [modeBits-1:0]   cur_mode,
  output logic                  busy,
  output logic                  done_stb,
  output logic                  err_stb
);

  localparam int HoldLen = (holdCycles < VMS_MIN_HOLD) ? VMS_MIN_HOLD : holdCycles;
  localparam int HoldW   = $clog2(HoldLen);
  localparam logic [HoldW-1:0]    HoldLast = HoldW'(HoldLen - 1);
  localparam logic [modeBits-1:0] DefMode  = modeBits'(defaultMode);

  video_mode_seq_state_t state;
  logic [HoldW-1:0]      hold_cnt;
  logic [modeBits-1:0]   next_mode;
  logic                  wd_enable;
  logic                  wd_expired;

  // Only WAIT_FRAME and SETTLE count, and every state change passes through a
  // non-counting state, so clearing whenever not counting restarts the
  // watchdog from zero on each entry.
  assign wd_enable = (state == VMS_WAIT_FRAME) || (state == VMS_SETTLE);

  video_mode_watchdog #(
    .timeoutBits (timeoutBits)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (!wd_enable),
    .enable  (wd_enable),
    .expired (wd_expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // Come out of reset mid-swap so power-up runs the normal start sequence.
      state      <= VMS_HOLD;
      hold_cnt   <= '0;
      next_mode  <= DefMode;
      timings    <= modes[defaultMode];
      cur_mode   <= DefMode;
      vt_reset_n <= 1'b0;
      req_ready  <= 1'b0;
      busy       <= 1'b1;
      done_stb   <= 1'b0;
      err_stb    <= 1'b0;
    end else begin
      done_stb <= 1'b0;
      err_stb  <= 1'b0;
      case (state)
        VMS_IDLE: begin
          if (req_valid && req_ready) begin
            if (int'(req_mode) >= numModes) begin
              err_stb <= 1'b1;
            end else if (req_mode == cur_mode) begin
              // Already running this preset: report done without touching the generator.
              state     <= VMS_DONE;
              done_stb  <= 1'b1;
              req_ready <= 1'b0;
              busy      <= 1'b1;
            end else begin
              next_mode <= req_mode;
              state     <= VMS_WAIT_FRAME;
              req_ready <= 1'b0;
              busy      <= 1'b1;
            end
          end
        end
        VMS_WAIT_FRAME: begin
          // A missing frame strobe must not wedge a mode change, so expiry swaps anyway.
          if (frame_stb || wd_expired) begin
            state      <= VMS_HOLD;
            hold_cnt   <= '0;
            vt_reset_n <= 1'b0;
            timings    <= modes[next_mode];
            cur_mode   <= next_mode;
          end
        end
        VMS_HOLD: begin
          if (hold_cnt == HoldLast) begin
            vt_reset_n <= 1'b1;
            state      <= VMS_SETTLE;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        VMS_SETTLE: begin
          if (frame_stb) begin
            state    <= VMS_DONE;
            done_stb <= 1'b1;
          end else if (wd_expired) begin
            state    <= VMS_DONE;
            done_stb <= 1'b1;
            err_stb  <= 1'b1;
          end
        end
        VMS_DONE: begin
          state     <= VMS_IDLE;
          req_ready <= 1'b1;
          busy      <= 1'b0;
        end
        default: begin
          state     <= VMS_IDLE;
          req_ready <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_video_mode_sequencer.sv
module tb_video_mode_sequencer;
  import video_mode_sequencer_pkg::*;

  localparam int NUM_MODES = 3;
  localparam int HOLD      = 8;
  localparam int TO_BITS   = 6;
  // Counter needs 2^n-1 counting edges to saturate, then one more edge to act on it.
  localparam int TIMEOUT_TICKS = (1 << TO_BITS);

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic req_valid = 1'b0;
  logic [1:0] req_mode = 2'd0;
  logic frame_stb = 1'b0;
  screenmode_timings tb_modes [NUM_MODES];

  logic req_ready, vt_reset_n, busy, done_stb, err_stb;
  logic [1:0] cur_mode;
  screenmode_timings timings;

  int n_checks = 0;
  int n_fail = 0;
  int exp_mode = 0;

  video_mode_sequencer #(
    .numModes    (NUM_MODES),
    .modeBits    (2),
    .defaultMode (0),
    .holdCycles  (HOLD),
    .timeoutBits (TO_BITS)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .modes      (tb_modes),
    .req_valid  (req_valid),
    .req_mode   (req_mode),
    .req_ready  (req_ready),
    .frame_stb  (frame_stb),
    .vt_reset_n (vt_reset_n),
    .timings    (timings),
    .cur_mode   (cur_mode),
    .busy       (busy),
    .done_stb   (done_stb),
    .err_stb    (err_stb)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic screenmode_timings rand_timings();
    screenmode_timings t;
    t.clkdiv    = 4'($urandom);
    t.hbstart   = 12'($urandom);
    t.hsstart   = 12'($urandom);
    t.hsstop    = 12'($urandom);
    t.htotal    = 12'($urandom);
    t.vbstart   = 12'($urandom);
    t.vsstart   = 12'($urandom);
    t.vsstop    = 12'($urandom);
    t.vtotal    = 12'($urandom);
    t.hpolarity = 1'($urandom);
    t.vpolarity = 1'($urandom);
    return t;
  endfunction

  // Asserts reset, checks the reset image, then runs the power-up start sequence.
  task automatic test_reset();
    int n;
    int d;
    int bad;
    reset = 1'b1;
    req_valid = 1'b0;
    frame_stb = 1'b0;
    #1;
    n_checks++;
    if (vt_reset_n !== 1'b0 || busy !== 1'b1 || req_ready !== 1'b0 || done_stb !== 1'b0 || err_stb !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: vt_reset_n=%b busy=%b req_ready=%b done=%b err=%b, required 0 1 0 0 0",
               vt_reset_n, busy, req_ready, done_stb, err_stb);
    end
    n_checks++;
    if (cur_mode !== 2'd0 || timings !== tb_modes[0]) begin
      n_fail++;
      $display("FAIL reset_mode: cur_mode=%0d timings=%h, required 0 %h", cur_mode, timings, tb_modes[0]);
    end
    tick();
    tick();
    reset = 1'b0;
    exp_mode = 0;
    n = 0;
    bad = 0;
    // frame_stb toggles randomly during hold: it must be ignored there.
    while (vt_reset_n === 1'b0 && n < 50) begin
      frame_stb = 1'($urandom);
      tick();
      n++;
      if (done_stb !== 1'b0) bad++;
    end
    frame_stb = 1'b0;
    n_checks++;
    if (n != HOLD || bad != 0) begin
      n_fail++;
      $display("FAIL reset_hold_len: low for %0d cycles with %0d early done, required %0d and 0", n, bad, HOLD);
    end
    d = $urandom_range(0, 30);
    repeat (d) begin
      tick();
      if (done_stb !== 1'b0) bad++;
    end
    frame_stb = 1'b1;
    tick();
    frame_stb = 1'b0;
    n_checks++;
    if (done_stb !== 1'b1 || err_stb !== 1'b0 || bad != 0) begin
      n_fail++;
      $display("FAIL reset_done: done=%b err=%b early=%0d, required 1 0 0", done_stb, err_stb, bad);
    end
    tick();
    n_checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0 || done_stb !== 1'b0 || cur_mode !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_idle: req_ready=%b busy=%b done=%b cur_mode=%0d, required 1 0 0 0",
               req_ready, busy, done_stb, cur_mode);
    end
  endtask

  task automatic test_mode_switch();
    for (int it = 0; it < 5; it++) begin
      int target;
      int old;
      int d;
      int n;
      int bad;
      old = exp_mode;
      target = (exp_mode + 1 + $urandom_range(0, 1)) % NUM_MODES;
      req_mode = 2'(target);
      req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      n_checks++;
      if (req_ready !== 1'b0 || busy !== 1'b1 || done_stb !== 1'b0) begin
        n_fail++;
        $display("FAIL sw_accept: req_ready=%b busy=%b done=%b, required 0 1 0", req_ready, busy, done_stb);
      end
      // Frame in progress: the generator must be untouched; extra requests are ignored.
      d = $urandom_range(1, 40);
      bad = 0;
      repeat (d) begin
        req_valid = 1'($urandom);
        req_mode = 2'($urandom);
        tick();
        if (vt_reset_n !== 1'b1 || cur_mode !== 2'(old) || timings !== tb_modes[old]) bad++;
      end
      req_valid = 1'b0;
      n_checks++;
      if (bad != 0) begin
        n_fail++;
        $display("FAIL sw_wait: %0d disturbed cycles before frame_stb, required 0", bad);
      end
      frame_stb = 1'b1;
      tick();
      frame_stb = 1'b0;
      exp_mode = target;
      n_checks++;
      if (vt_reset_n !== 1'b0 || cur_mode !== 2'(target) || timings !== tb_modes[target]) begin
        n_fail++;
        $display("FAIL sw_hold_entry: vt_reset_n=%b cur_mode=%0d timings=%h, required 0 %0d %h",
                 vt_reset_n, cur_mode, timings, target, tb_modes[target]);
      end
      n = 1;
      while (n < 50) begin
        frame_stb = 1'($urandom);
        tick();
        if (vt_reset_n !== 1'b0) break;
        n++;
      end
      frame_stb = 1'b0;
      n_checks++;
      if (n != HOLD || done_stb !== 1'b0) begin
        n_fail++;
        $display("FAIL sw_hold_len: low %0d cycles done=%b, required %0d and 0", n, done_stb, HOLD);
      end
      d = $urandom_range(0, 40);
      bad = 0;
      repeat (d) begin
        tick();
        if (done_stb !== 1'b0) bad++;
      end
      frame_stb = 1'b1;
      tick();
      frame_stb = 1'b0;
      n_checks++;
      if (done_stb !== 1'b1 || err_stb !== 1'b0 || cur_mode !== 2'(target) || bad != 0) begin
        n_fail++;
        $display("FAIL sw_done: done=%b err=%b cur_mode=%0d early=%0d, required 1 0 %0d 0",
                 done_stb, err_stb, cur_mode, bad, target);
      end
      tick();
      n_checks++;
      if (req_ready !== 1'b1 || busy !== 1'b0 || done_stb !== 1'b0) begin
        n_fail++;
        $display("FAIL sw_idle: req_ready=%b busy=%b done=%b, required 1 0 0", req_ready, busy, done_stb);
      end
    end
  endtask

  task automatic test_same_mode();
    req_mode = 2'(exp_mode);
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    n_checks++;
    if (done_stb !== 1'b1 || err_stb !== 1'b0 || vt_reset_n !== 1'b1 || req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL same_done: done=%b err=%b vt_reset_n=%b req_ready=%b, required 1 0 1 0",
               done_stb, err_stb, vt_reset_n, req_ready);
    end
    tick();
    n_checks++;
    if (req_ready !== 1'b1 || done_stb !== 1'b0 || vt_reset_n !== 1'b1 ||
        cur_mode !== 2'(exp_mode) || timings !== tb_modes[exp_mode]) begin
      n_fail++;
      $display("FAIL same_idle: req_ready=%b done=%b vt_reset_n=%b cur_mode=%0d, required 1 0 1 %0d",
               req_ready, done_stb, vt_reset_n, cur_mode, exp_mode);
    end
  endtask

  task automatic test_out_of_range();
    req_mode = 2'd3;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    n_checks++;
    if (err_stb !== 1'b1 || done_stb !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL oor_err: err=%b done=%b req_ready=%b busy=%b, required 1 0 1 0",
               err_stb, done_stb, req_ready, busy);
    end
    n_checks++;
    if (cur_mode !== 2'(exp_mode) || timings !== tb_modes[exp_mode] || vt_reset_n !== 1'b1) begin
      n_fail++;
      $display("FAIL oor_keep: cur_mode=%0d timings=%h vt_reset_n=%b, required %0d %h 1",
               cur_mode, timings, vt_reset_n, exp_mode, tb_modes[exp_mode]);
    end
    tick();
    n_checks++;
    if (err_stb !== 1'b0) begin
      n_fail++;
      $display("FAIL oor_pulse: err=%b one cycle later, required 0", err_stb);
    end
  endtask

  task automatic test_timeout();
    int target;
    int n;
    target = (exp_mode == 2) ? 0 : 2;
    req_mode = 2'(target);
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    n = 0;
    while (vt_reset_n === 1'b1 && n < 200) begin
      tick();
      n++;
    end
    exp_mode = target;
    n_checks++;
    if (n != TIMEOUT_TICKS || cur_mode !== 2'(target) || err_stb !== 1'b0) begin
      n_fail++;
      $display("FAIL to_wait: hold after %0d cycles cur_mode=%0d err=%b, required %0d %0d 0",
               n, cur_mode, err_stb, TIMEOUT_TICKS, target);
    end
    n = 0;
    while (vt_reset_n === 1'b0 && n < 50) begin
      tick();
      n++;
    end
    n_checks++;
    if (n != HOLD) begin
      n_fail++;
      $display("FAIL to_hold_len: low %0d cycles, required %0d", n, HOLD);
    end
    n = 0;
    while (done_stb !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    n_checks++;
    if (n != TIMEOUT_TICKS || err_stb !== 1'b1) begin
      n_fail++;
      $display("FAIL to_settle: done after %0d cycles err=%b, required %0d and 1", n, err_stb, TIMEOUT_TICKS);
    end
    tick();
    n_checks++;
    if (req_ready !== 1'b1 || err_stb !== 1'b0 || done_stb !== 1'b0) begin
      n_fail++;
      $display("FAIL to_idle: req_ready=%b err=%b done=%b, required 1 0 0", req_ready, err_stb, done_stb);
    end
  endtask

  task automatic test_reset_mid();
    req_mode = 2'd1;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    frame_stb = 1'b1;
    tick();
    frame_stb = 1'b0;
    n_checks++;
    if (cur_mode !== 2'd1 || timings !== tb_modes[1] || vt_reset_n !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_hold: cur_mode=%0d vt_reset_n=%b timings=%h, required 1 0 %h",
               cur_mode, vt_reset_n, timings, tb_modes[1]);
    end
    repeat (3) tick();
    test_reset();
  endtask

  initial begin
    for (int i = 0; i < NUM_MODES; i++) tb_modes[i] = rand_timings();
    #2;
    test_reset();
    test_mode_switch();
    test_same_mode();
    test_out_of_range();
    test_timeout();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
